// File: rtl/sequential_divider_pkg.sv
// sequential_divider_pkg: shared widths, FSM state encodings and divide-by-zero result.
package sequential_divider_pkg;
  localparam int OP_W = 8;
  localparam int REM_W = 9;
  localparam logic [OP_W-1:0] DIV0_QUOTIENT = 8'hFF;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t LOAD = 2'd1;
  localparam state_t CALC = 2'd2;
  localparam state_t DONE = 2'd3;
endpackage

// File: rtl/sequential_divider_if.sv
// sequential_divider_if: Run/operand front end and result bus of the divider.
interface sequential_divider_if;
  import sequential_divider_pkg::*;
  logic Run;
  logic [OP_W-1:0] Dividend;
  logic [OP_W-1:0] Divisor;
  logic [OP_W-1:0] Quotient;
  logic [OP_W-1:0] Remainder;
  logic Busy;
  logic Done;
  logic DivByZero;
  modport master(output Run, Dividend, Divisor, input Quotient, Remainder, Busy, Done, DivByZero);
  modport slave(input Run, Dividend, Divisor, output Quotient, Remainder, Busy, Done, DivByZero);
endinterface

// File: rtl/sequential_divider_addsub9.sv
// addsub9: 9-bit ripple add/subtract; sub inverts B and supplies the carry-in.
module addsub9
  import sequential_divider_pkg::*;
(
  input  logic [REM_W-1:0] A,
  input  logic [REM_W-1:0] B,
  input  logic             sub,
  output logic [REM_W-1:0] S,
  output logic             cout
);
  logic [REM_W-1:0] bx;
  logic [REM_W:0] c;
  assign bx = B ^ {REM_W{sub}};
  assign c[0] = sub;
  for (genvar i = 0; i < REM_W; i++) begin : g_fa
    assign S[i] = A[i] ^ bx[i] ^ c[i];
    assign c[i+1] = (A[i] & bx[i]) | (c[i] & (A[i] ^ bx[i]));
  end
  assign cout = c[REM_W];
endmodule

// File: rtl/sequential_divider.sv
// sequential_divider: iterative 8-bit unsigned restoring divider, one quotient bit per cycle.
module sequential_divider
  import sequential_divider_pkg::*;
(
  input logic Clk,
  input logic Reset,
  sequential_divider_if.slave bus
);
  state_t state;
  logic [REM_W-1:0] r, s, t, r_next;
  logic [OP_W-1:0] q, d, q_next;
  logic [2:0] cnt;
  logic co;
  assign s = {r[OP_W-1:0], q[OP_W-1]};
  addsub9 u_addsub (.A(s), .B({1'b0, d}), .sub(1'b1), .S(t), .cout(co));
  // carry-out set means the trial subtraction did not borrow
  assign r_next = co ? t : s;
  assign q_next = {q[OP_W-2:0], co};
  assign bus.Busy = (state == LOAD) || (state == CALC);
  assign bus.Done = state == DONE;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      r <= '0;
      q <= '0;
      d <= '0;
      cnt <= '0;
      bus.Quotient <= '0;
      bus.Remainder <= '0;
      bus.DivByZero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.Run) state <= LOAD;
        LOAD: begin
          r <= '0;
          q <= bus.Dividend;
          d <= bus.Divisor;
          cnt <= '0;
          bus.DivByZero <= bus.Divisor == '0;
          state <= bus.Divisor == '0 ? DONE : CALC;
          if (bus.Divisor == '0) begin
            bus.Quotient <= DIV0_QUOTIENT;
            bus.Remainder <= bus.Dividend;
          end
        end
        CALC: begin
          r <= r_next;
          q <= q_next;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            bus.Quotient <= q_next;
            bus.Remainder <= r_next[OP_W-1:0];
            state <= DONE;
          end
        end
        default: if (!bus.Run) state <= IDLE;
      endcase
    end
  end
endmodule
